// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM access controller.
package sram_pkg;

  localparam int SRAM_DATA_W   = 16;
  localparam int CPU_DATA_W    = 32;
  localparam int ADDR_W_DEF    = 18;
  localparam int BASE_ADDR_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sram_access_ctrl_if.sv
// CPU-side load/store handshake between the MEM stage and the SRAM controller.
interface sram_access_ctrl_if;
  import sram_pkg::*;

  logic                  mem_read;
  logic                  mem_write;
  logic [CPU_DATA_W-1:0] address;
  logic [CPU_DATA_W-1:0] write_data;
  logic [CPU_DATA_W-1:0] read_data;
  logic                  ready;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_addr_map.sv
// Maps a CPU byte address onto an SRAM halfword address.
module sram_addr_map
  import sram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic [CPU_DATA_W-1:0] byte_addr_i,
  input  logic                  half_i,
  output logic [ADDR_W-1:0]     haddr_o
);

  logic [CPU_DATA_W-1:0] off;
  logic                  unused_bits;

  assign off = byte_addr_i - CPU_DATA_W'(BASE_ADDR);

  // Word index wraps modulo the SRAM size.
  assign haddr_o = {off[ADDR_W:2], half_i};

  assign unused_bits = ^{off[CPU_DATA_W-1:ADDR_W+1], off[1:0]};

endmodule

// File: rtl/sram_access_ctrl.sv
// MEM-stage responder: one 32-bit load/store as two 16-bit SRAM accesses.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BASE_ADDR   = BASE_ADDR_DEF,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_access_ctrl_if.slave      cpu,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e                  state_q, state_d;
  logic [CPU_DATA_W-1:0]   addr_q, addr_d;
  logic [CPU_DATA_W-1:0]   wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CPU_DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]       saddr_q, saddr_d;
  logic [SRAM_DATA_W-1:0]  dq_q, dq_d;

  logic                    req;
  logic                    access;
  logic [CPU_DATA_W-1:0]   map_byte;
  logic                    map_half;
  logic [ADDR_W-1:0]       map_haddr;

  assign req    = cpu.mem_read | cpu.mem_write;
  assign access = (state_q == ST_LOW) || (state_q == ST_HIGH);

  // IDLE maps the incoming low half; LOW maps the latched high half.
  assign map_byte = (state_q == ST_IDLE) ? cpu.address : addr_q;
  assign map_half = (state_q != ST_IDLE);

  sram_addr_map #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) u_map (
    .byte_addr_i(map_byte),
    .half_i     (map_half),
    .haddr_o    (map_haddr)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    saddr_d = saddr_q;
    dq_d    = dq_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_LOW;
          addr_d  = cpu.address;
          wdata_d = cpu.write_data;
          wr_d    = cpu.mem_write;
          saddr_d = map_haddr;
          if (cpu.mem_write) dq_d = cpu.write_data[15:0];
        end
      end
      ST_LOW: begin
        state_d = ST_HIGH;
        saddr_d = map_haddr;
        if (wr_q) dq_d = wdata_q[31:16];
        else      rdata_d[15:0] = sram_dq_in;
      end
      ST_HIGH: begin
        state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DONE;
        cnt_d   = '0;
        if (!wr_q) rdata_d[31:16] = sram_dq_in;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) state_d = ST_DONE;
        else cnt_d = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      saddr_q <= '0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      saddr_q <= saddr_d;
      dq_q    <= dq_d;
    end
  end

  // Strobes are forced inactive during reset so a pending store is dropped.
  always_comb begin
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_dq_oe = 1'b0;
    if (!rst && access) begin
      if (wr_q) begin
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end else begin
        sram_oe_n  = 1'b0;
      end
    end
  end

  assign cpu.ready = rst ? !req
                   : (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);

  assign cpu.read_data = rdata_q;
  assign sram_addr     = saddr_q;
  assign sram_dq_out   = dq_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl with a word-level memory model.
module tb_sram_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_access_ctrl_if ifc();
  sram_access_ctrl_if ifc3();

  logic [17:0] sa, sa3;
  logic [15:0] sdo, sdo3, sdi, sdi3;
  logic        soe, soe3, swe_n, swe3_n, sroe_n, sroe3_n;

  bit [15:0] sram0 [262144];
  bit [15:0] sram3 [262144];

  sram_access_ctrl #(.WAIT_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .cpu(ifc),
    .sram_addr(sa), .sram_dq_out(sdo), .sram_dq_in(sdi),
    .sram_dq_oe(soe), .sram_we_n(swe_n), .sram_oe_n(sroe_n)
  );

  sram_access_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .cpu(ifc3),
    .sram_addr(sa3), .sram_dq_out(sdo3), .sram_dq_in(sdi3),
    .sram_dq_oe(soe3), .sram_we_n(swe3_n), .sram_oe_n(sroe3_n)
  );

  assign sdi  = sram0[sa];
  assign sdi3 = sram3[sa3];
  always @(posedge clk) if (!swe_n) sram0[sa] <= sdo;
  always @(posedge clk) if (!swe3_n) sram3[sa3] <= sdo3;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc++;

  task automatic chk(bit ok, string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { bit rd; logic [31:0] data; int start; } comp_t;
  typedef struct { bit we; logic [17:0] a; logic [15:0] d; } pin_t;
  comp_t cq[$];
  pin_t  pq[$];

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] rd_model = '0;

  function automatic int unsigned word_of(logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return (off >> 2) & 32'h1FFFF;
  endfunction

  function automatic logic [31:0] getm(int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic logic [17:0] hw(int unsigned w, bit h);
    logic [16:0] w17;
    w17 = w[16:0];
    return {w17, h};
  endfunction

  // Monitor: a rising ready marks completion; any active strobe is a pin access.
  bit prev_rdy = 1'b1;
  bit after_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy = 1'b1;
      after_done = 1'b0;
    end else begin
      if (after_done) begin
        if (ifc.mem_read || ifc.mem_write)
          chk(!ifc.ready, "ready_one_cycle", 64'(ifc.ready), 64'd0);
        after_done = 1'b0;
      end
      if (ifc.ready && !prev_rdy) begin
        if (cq.size() == 0) begin
          chk(1'b0, "spurious_done", 64'd1, 64'd0);
        end else begin
          comp_t it;
          it = cq.pop_front();
          chk(cyc - it.start == 3, "latency", 64'(cyc - it.start), 64'd3);
          chk(ifc.read_data === it.data, it.rd ? "load_data" : "store_rdata",
              64'(ifc.read_data), 64'(it.data));
        end
        done_cnt++;
        after_done = 1'b1;
      end
      prev_rdy = ifc.ready;
      if (!swe_n || !sroe_n || soe) begin
        if (pq.size() == 0) begin
          chk(1'b0, "spurious_pin", {61'd0, ~swe_n, ~sroe_n, soe}, 64'd0);
        end else begin
          pin_t p;
          logic [63:0] act, exp;
          p = pq.pop_front();
          act = {43'd0, ~swe_n, ~sroe_n, soe, sa, p.we ? sdo : 16'h0};
          exp = {43'd0, p.we, ~p.we, p.we, p.a, p.we ? p.d : 16'h0};
          chk(act === exp, p.we ? "pin_store" : "pin_load", act, exp);
        end
      end
    end
  end

  task automatic do_req(bit rd, bit wr, logic [31:0] a, logic [31:0] d,
                        bit drop, output int st);
    int unsigned w;
    int base;
    int n;
    w = word_of(a);
    @(posedge clk); #1;
    ifc.mem_read = rd;
    ifc.mem_write = wr;
    ifc.address = a;
    ifc.write_data = d;
    st = cyc;
    if (wr) begin
      pq.push_back('{1'b1, hw(w, 1'b0), d[15:0]});
      pq.push_back('{1'b1, hw(w, 1'b1), d[31:16]});
      ref_mem[w] = d;
      cq.push_back('{1'b0, rd_model, cyc});
    end else begin
      pq.push_back('{1'b0, hw(w, 1'b0), 16'h0});
      pq.push_back('{1'b0, hw(w, 1'b1), 16'h0});
      rd_model = getm(w);
      cq.push_back('{1'b1, rd_model, cyc});
    end
    base = done_cnt;
    if (drop) begin
      @(posedge clk); #1;
      ifc.mem_read = 1'b0;
      ifc.mem_write = 1'b0;
      ifc.address = $urandom;
      ifc.write_data = $urandom;
    end
    n = 0;
    while (done_cnt == base && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == base) chk(1'b0, "timeout", 64'(n), 64'd3);
  endtask

  task automatic idle(int n);
    @(posedge clk); #1;
    ifc.mem_read = 1'b0;
    ifc.mem_write = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    int st1, st2, lows;
    ifc.mem_read = 0; ifc.mem_write = 0;
    ifc.address = 0; ifc.write_data = 0;
    ifc3.mem_read = 0; ifc3.mem_write = 0;
    ifc3.address = 0; ifc3.write_data = 0;
    sram0[0] = 16'hBEEF;
    sram0[1] = 16'hDEAD;
    ref_mem[0] = 32'hDEADBEEF;
    sram3[10] = 16'h5678;
    sram3[11] = 16'h1234;

    repeat (2) @(negedge clk);
    chk(ifc.ready === 1'b1, "rst_ready_idle", 64'(ifc.ready), 64'd1);
    chk({swe_n, sroe_n, soe} === 3'b110, "rst_strobes",
        64'({swe_n, sroe_n, soe}), 64'd6);
    chk(ifc.read_data === 32'h0, "rst_rdata", 64'(ifc.read_data), 64'd0);
    chk({sa, sdo} === 34'h0, "rst_pins", 64'({sa, sdo}), 64'd0);
    ifc.mem_read = 1'b1;
    #1;
    chk(ifc.ready === 1'b0, "rst_ready_req", 64'(ifc.ready), 64'd0);
    ifc.mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(1, 0, 32'd1024, 32'h0, 0, st1);
    do_req(0, 1, 32'd1024, 32'hDEADBEEF, 0, st1);
    idle(2);
    do_req(0, 1, 32'd1032, 32'hABCD1234, 0, st1);
    do_req(1, 0, 32'd1032, 32'h0, 0, st2);
    chk(st2 - st1 == 4, "b2b_start", 64'(st2 - st1), 64'd4);
    do_req(1, 1, 32'd1028, 32'h13572468, 0, st1);
    idle(2);
    do_req(1, 0, 32'd1028, 32'h0, 1, st1);

    for (int i = 0; i < 60; i++) begin
      int unsigned r, ws, wv;
      logic [31:0] a;
      r  = $urandom_range(0, 9);
      ws = $urandom_range(0, 16);
      wv = (ws == 16) ? 32'h1FFFF : ws;
      a  = 32'd1024 + 4 * wv + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) a = a + 32'h80000;
      do_req(r < 4 || r >= 8, r >= 4, a, $urandom,
             $urandom_range(0, 4) == 0, st1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    begin
      int unsigned w;
      logic [31:0] d;
      d = 32'hCAFEF00D;
      w = word_of(32'd1040);
      @(posedge clk); #1;
      ifc.mem_write = 1'b1;
      ifc.address = 32'd1040;
      ifc.write_data = d;
      pq.push_back('{1'b1, hw(w, 1'b0), d[15:0]});
      ref_mem[w] = {getm(w) >> 16, d[15:0]};
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      ifc.mem_write = 1'b0;
      @(negedge clk);
      chk({swe_n, soe} === 2'b10, "rst_mid_strobes", 64'({swe_n, soe}), 64'd2);
      @(posedge clk); #1;
      rst = 1'b0;
      rd_model = 32'h0;
      @(negedge clk);
      chk({swe_n, sroe_n, soe, ifc.ready} === 4'b1101, "post_rst_idle",
          64'({swe_n, sroe_n, soe, ifc.ready}), 64'hD);
      chk(ifc.read_data === 32'h0, "post_rst_rdata", 64'(ifc.read_data), 64'd0);
      do_req(0, 1, 32'd1044, 32'h0BADC0DE, 0, st1);
      do_req(1, 0, 32'd1040, 32'h0, 0, st1);
      idle(2);
    end

    @(posedge clk); #1;
    ifc3.mem_read = 1'b1;
    ifc3.address = 32'd1044;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!ifc3.ready) lows++;
    end
    chk(lows == 6, "wait3_ready_low", 64'(lows), 64'd6);
    @(negedge clk);
    chk(ifc3.ready === 1'b1, "wait3_ready_k6", 64'(ifc3.ready), 64'd1);
    chk(ifc3.read_data === 32'h12345678, "wait3_data",
        64'(ifc3.read_data), 64'h12345678);
    @(posedge clk); #1;
    ifc3.mem_read = 1'b0;
    idle(3);

    chk(cq.size() == 0, "cq_empty", 64'(cq.size()), 64'd0);
    chk(pq.size() == 0, "pq_empty", 64'(pq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
